fp32_to_int32_conv: RTL and testbench

Multicycle converter from IEEE-754 single precision to 32-bit signed two's-complement integer, with the same status encoding as the FPU add/sub datapath. It is the decoding end of the FPU result path: it takes an encoded float such as the FPU's `data_out` and returns an integer plus a one-hot status. It sits downstream of the FPU, in front of integer consumers.

---
 rtl/fp32_to_int32_conv.sv | 257 +++++++++++++++++++++++++
 tb/tb_fp32_to_int32_conv.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_conv.sv
// ---------------------------------------------------------------------------
// fp32_to_int32_conv
//   Multicycle IEEE-754 single-precision to signed 32-bit integer converter.
//   A request passes through five states, so latency is always 4 edges
//   after capture. The status encoding matches the FPU add/sub datapath.
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   S_IDLE     | waiting for start; captures fp_in and rnd_mode
//   S_DECODE   | classifies NaN / inf / zero / saturation / normal operand
//   S_SHIFT    | aligns the significand, extracts guard and sticky bits
//   S_ROUND    | applies the rounding increment, detects range overflow
//   S_FINALIZE | applies the sign, selects the status, registers the result
//
// Ports
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   conversion request, sampled only in S_IDLE
//   fp_in       in   [31:0] IEEE-754 operand, captured with start
//   rnd_mode    in   0 = truncate toward zero, 1 = round-to-nearest-even
//   data_out    out  [31:0] signed integer result, held until the next done
//   status_out  out  [3:0] one-hot: 0001 EXACT, 0010 OVERFLOW,
//                    0100 INEXACT, 1000 INVALID
//   busy        out  high while a conversion is in flight
//   done        out  one-cycle pulse when data_out/status_out update
// ---------------------------------------------------------------------------
module fp32_to_int32_conv (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] fp_in,
    input  logic        rnd_mode,
    output logic [31:0] data_out,
    output logic [3:0]  status_out,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] ST_EXACT    = 4'b0001;
    localparam logic [3:0] ST_OVERFLOW = 4'b0010;
    localparam logic [3:0] ST_INEXACT  = 4'b0100;
    localparam logic [3:0] ST_INVALID  = 4'b1000;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DECODE   = 3'd1,
        S_SHIFT    = 3'd2,
        S_ROUND    = 3'd3,
        S_FINALIZE = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Captured operand
    logic        sign_q,  sign_d;
    logic [7:0]  exp_q,   exp_d;
    logic [22:0] frac_q,  frac_d;
    logic        rnd_q,   rnd_d;

    // Special-class bypass: result is either 0 or the signed saturation value
    logic        byp_q,      byp_d;
    logic        byp_zero_q, byp_zero_d;
    logic [3:0]  byp_stat_q, byp_stat_d;

    // Normal-path datapath
    logic [31:0] mag_q,     mag_d;
    logic        guard_q,   guard_d;
    logic        sticky_q,  sticky_d;
    logic        ovf_q,     ovf_d;
    logic        inexact_q, inexact_d;

    // Outputs
    logic [31:0] data_q,   data_d;
    logic [3:0]  status_q, status_d;
    logic        done_q,   done_d;

    // Shift / round helpers
    logic [23:0] sig;
    logic [7:0]  rsh_raw;
    logic [4:0]  rsh;
    logic [49:0] ext;
    logic        rnd_inc;
    logic [32:0] mag_r;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (start) state_d = S_DECODE;
            S_DECODE:   state_d = S_SHIFT;
            S_SHIFT:    state_d = S_ROUND;
            S_ROUND:    state_d = S_FINALIZE;
            S_FINALIZE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    assign sig = {1'b1, frac_q};

    // Right-shift amount 23 - u = 150 - e. Anything past 26 already shifts
    // the whole significand below the sticky position, so clamp it there.
    assign rsh_raw = 8'd150 - exp_q;
    assign rsh     = (rsh_raw > 8'd26) ? 5'd26 : rsh_raw[4:0];
    // Significand in the top 24 bits; bit 25 becomes guard, bits 24:0 sticky.
    assign ext     = {sig, 26'd0} >> rsh;

    assign rnd_inc = rnd_q & guard_q & (sticky_q | mag_q[0]);
    assign mag_r   = {1'b0, mag_q} + {32'd0, rnd_inc};

    always_comb begin
        sign_d     = sign_q;
        exp_d      = exp_q;
        frac_d     = frac_q;
        rnd_d      = rnd_q;
        byp_d      = byp_q;
        byp_zero_d = byp_zero_q;
        byp_stat_d = byp_stat_q;
        mag_d      = mag_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        ovf_d      = ovf_q;
        inexact_d  = inexact_q;
        data_d     = data_q;
        status_d   = status_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d = fp_in[31];
                    exp_d  = fp_in[30:23];
                    frac_d = fp_in[22:0];
                    rnd_d  = rnd_mode;
                end
            end

            S_DECODE: begin
                byp_d      = 1'b1;
                byp_zero_d = 1'b0;
                byp_stat_d = ST_OVERFLOW;
                if (exp_q == 8'd255 && frac_q != 23'd0) begin
                    byp_zero_d = 1'b1;
                    byp_stat_d = ST_INVALID;
                end else if (exp_q == 8'd255) begin
                    byp_stat_d = ST_OVERFLOW;
                end else if (exp_q == 8'd0) begin
                    byp_zero_d = 1'b1;
                    byp_stat_d = (frac_q == 23'd0) ? ST_EXACT : ST_INEXACT;
                end else if (exp_q == 8'd158 && frac_q == 23'd0 && sign_q) begin
                    // -2^31 is representable; saturation value equals it
                    byp_stat_d = ST_EXACT;
                end else if (exp_q >= 8'd158) begin
                    byp_stat_d = ST_OVERFLOW;
                end else begin
                    byp_d = 1'b0;
                end
            end

            S_SHIFT: begin
                // e >= 150 is u >= 23: integer already, shift left by u - 23
                if (exp_q >= 8'd150) begin
                    mag_d    = {8'd0, sig} << (exp_q - 8'd150);
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                end else begin
                    mag_d    = {8'd0, ext[49:26]};
                    guard_d  = ext[25];
                    sticky_d = |ext[24:0];
                end
            end

            S_ROUND: begin
                inexact_d = guard_q | sticky_q;
                mag_d     = mag_r[31:0];
                if (sign_q) begin
                    ovf_d = (mag_r > 33'h0_8000_0000);
                end else begin
                    ovf_d = (mag_r > 33'h0_7FFF_FFFF);
                end
            end

            S_FINALIZE: begin
                done_d = 1'b1;
                if (byp_q) begin
                    data_d   = byp_zero_q ? 32'd0 : (sign_q ? SAT_NEG : SAT_POS);
                    status_d = byp_stat_q;
                end else if (ovf_q) begin
                    data_d   = sign_q ? SAT_NEG : SAT_POS;
                    status_d = ST_OVERFLOW;
                end else begin
                    data_d   = sign_q ? (~mag_q + 32'd1) : mag_q;
                    status_d = inexact_q ? ST_INEXACT : ST_EXACT;
                end
            end

            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sign_q     <= 1'b0;
            exp_q      <= 8'd0;
            frac_q     <= 23'd0;
            rnd_q      <= 1'b0;
            byp_q      <= 1'b0;
            byp_zero_q <= 1'b0;
            byp_stat_q <= 4'd0;
            mag_q      <= 32'd0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            ovf_q      <= 1'b0;
            inexact_q  <= 1'b0;
            data_q     <= 32'd0;
            status_q   <= 4'd0;
            done_q     <= 1'b0;
        end else begin
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            frac_q     <= frac_d;
            rnd_q      <= rnd_d;
            byp_q      <= byp_d;
            byp_zero_q <= byp_zero_d;
            byp_stat_q <= byp_stat_d;
            mag_q      <= mag_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            ovf_q      <= ovf_d;
            inexact_q  <= inexact_d;
            data_q     <= data_d;
            status_q   <= status_d;
            done_q     <= done_d;
        end
    end

    assign data_out   = data_q;
    assign status_out = status_q;
    assign done       = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fp32_to_int32_conv.sv
// ---------------------------------------------------------------------------
// tb_fp32_to_int32_conv
//   Directed-vector bench for fp32_to_int32_conv with hand-computed
//   expected integers and status codes, plus handshake and reset checks.
// ---------------------------------------------------------------------------
module tb_fp32_to_int32_conv;

    localparam logic [3:0] EXACT    = 4'b0001;
    localparam logic [3:0] OVERFLOW = 4'b0010;
    localparam logic [3:0] INEXACT  = 4'b0100;
    localparam logic [3:0] INVALID  = 4'b1000;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] fp_in;
    logic        rnd_mode;
    logic [31:0] data_out;
    logic [3:0]  status_out;
    logic        busy;
    logic        done;

    int n_vec;
    int n_err;

    fp32_to_int32_conv dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .fp_in      (fp_in),
        .rnd_mode   (rnd_mode),
        .data_out   (data_out),
        .status_out (status_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // One conversion: capture at T0, then sample #1 after the 4th edge.
    task automatic conv(input string tag, input logic [31:0] fp, input logic rm,
                        input logic [31:0] exp_data, input logic [3:0] exp_stat);
        @(negedge clk);
        start    = 1'b1;
        fp_in    = fp;
        rnd_mode = rm;
        @(posedge clk);
        #1;
        start    = 1'b0;
        fp_in    = 32'hDEAD_BEEF;
        rnd_mode = ~rm;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_nodone"}, {31'd0, done}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        chk({tag, "_data"}, data_out, exp_data);
        chk({tag, "_stat"}, {28'd0, status_out}, {28'd0, exp_stat});
    endtask

    int done_cnt;
    int first_done;
    int second_done;

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        fp_in    = 32'd0;
        rnd_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", data_out, 32'd0);
        chk("rst_stat", {28'd0, status_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        conv("one",       32'h3F80_0000, 1'b0, 32'h0000_0001, EXACT);
        conv("3p5_trunc", 32'h4060_0000, 1'b0, 32'h0000_0003, INEXACT);
        conv("3p5_rne",   32'h4060_0000, 1'b1, 32'h0000_0004, INEXACT);
        conv("m2p5_rne",  32'hC020_0000, 1'b1, 32'hFFFF_FFFE, INEXACT);
        conv("0p75_rne",  32'h3F40_0000, 1'b1, 32'h0000_0001, INEXACT);
        conv("0p5_rne",   32'h3F00_0000, 1'b1, 32'h0000_0000, INEXACT);
        conv("1p5_rne",   32'h3FC0_0000, 1'b1, 32'h0000_0002, INEXACT);
        conv("m1p5_trunc",32'hBFC0_0000, 1'b0, 32'hFFFF_FFFF, INEXACT);
        conv("sub1_rne",  32'h3F7F_FFFF, 1'b1, 32'h0000_0001, INEXACT);
        conv("sub1_trunc",32'h3F7F_FFFF, 1'b0, 32'h0000_0000, INEXACT);
        conv("pow31",     32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, OVERFLOW);
        conv("mpow31",    32'hCF00_0000, 1'b0, 32'h8000_0000, EXACT);
        conv("max_pos",   32'h4EFF_FFFF, 1'b0, 32'h7FFF_FF80, EXACT);
        conv("max_neg",   32'hCEFF_FFFF, 1'b1, 32'h8000_0080, EXACT);
        conv("pow30",     32'h4E80_0000, 1'b0, 32'h4000_0000, EXACT);
        conv("pow23p1",   32'h4B00_0001, 1'b1, 32'h0080_0001, EXACT);
        conv("ninf",      32'hFF80_0000, 1'b0, 32'h8000_0000, OVERFLOW);
        conv("pinf",      32'h7F80_0000, 1'b1, 32'h7FFF_FFFF, OVERFLOW);
        conv("nan",       32'h7FC0_0000, 1'b0, 32'h0000_0000, INVALID);
        conv("negzero",   32'h8000_0000, 1'b1, 32'h0000_0000, EXACT);
        conv("denorm",    32'h0000_0001, 1'b1, 32'h0000_0000, INEXACT);

        // start pulses while busy must be ignored: exactly one done
        @(negedge clk);
        start    = 1'b1;
        fp_in    = 32'h4060_0000;
        rnd_mode = 1'b0;
        done_cnt = 0;
        @(posedge clk);
        #1;
        fp_in = 32'h3F80_0000;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = (i == 1 || i == 2 || i == 3);
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        start = 1'b0;
        chk("busy_ign_cnt", done_cnt, 1);
        chk("busy_ign_data", data_out, 32'h0000_0003);

        // reset while in S_ROUND: outputs clear at once, no done follows
        @(negedge clk);
        start    = 1'b1;
        fp_in    = 32'h3F80_0000;
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_data", data_out, 32'd0);
        chk("arst_stat", {28'd0, status_out}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("arst_nodone", done_cnt, 0);

        // start held high: captures every 5 cycles
        @(negedge clk);
        start       = 1'b1;
        fp_in       = 32'hC020_0000;
        rnd_mode    = 1'b1;
        first_done  = -1;
        second_done = -1;
        for (int i = 0; i <= 11; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_done < 0) first_done = i;
                else if (second_done < 0) second_done = i;
            end
        end
        start = 1'b0;
        chk("b2b_first", first_done, 4);
        chk("b2b_second", second_done, 9);
        chk("b2b_data", data_out, 32'hFFFF_FFFE);
        chk("b2b_stat", {28'd0, status_out}, {28'd0, INEXACT});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
